// File: rtl/cargador_programa_if.sv
// Byte-stream handshake between an external program source and the boot loader.
interface cargador_programa_if;
  logic [7:0] byte_dato;
  logic       byte_valido;
  logic       byte_listo;

  modport master (output byte_dato, output byte_valido, input byte_listo);
  modport slave  (input byte_dato, input byte_valido, output byte_listo);
endinterface

// File: rtl/cargador_programa.sv
// Boot-time program loader: assembles little-endian words from a byte stream into RAM,
// then releases the CPU and hands it the RAM port.
module cargador_programa #(
  parameter int PALABRAS  = 512,
  parameter int ANCHO_DIR = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inicio,
  input  logic [9:0]            n_palabras,
  cargador_programa_if.slave    bus,
  input  logic [31:0]           cpu_dir,
  input  logic [31:0]           cpu_dat_escritura,
  input  logic                  cpu_hab_escritura,
  output logic [ANCHO_DIR-1:0]  ram_dir,
  output logic [31:0]           ram_din,
  output logic                  ram_we,
  output logic                  cpu_reset,
  output logic                  ocupado,
  output logic                  hecho
);

  typedef enum logic [1:0] {REPOSO = 2'd0, CARGA = 2'd1, FIN = 2'd2, EJECUTA = 2'd3} estado_t;

  estado_t              r_estado;
  estado_t              w_siguiente;
  logic [9:0]           r_cuenta;
  logic [9:0]           r_indice;
  logic [1:0]           r_byte_cnt;
  logic [23:0]          r_ensamble;
  logic [31:0]          r_escritura;
  logic [ANCHO_DIR-1:0] r_dir;
  logic                 r_we;

  logic                 w_listo;
  logic                 w_acepta;
  logic                 w_ultimo_byte;
  logic                 w_ultima_palabra;
  logic [9:0]           w_cuenta_lim;
  logic                 w_unused_cpu_dir;

  assign w_listo          = (r_estado == CARGA);
  assign w_acepta         = w_listo & bus.byte_valido;
  assign w_ultimo_byte    = w_acepta & (r_byte_cnt == 2'd3);
  assign w_ultima_palabra = (r_indice == (r_cuenta - 10'd1));
  // Clamping keeps the word index within RAM, so it can never wrap.
  assign w_cuenta_lim     = ({1'b0, n_palabras} > 11'(PALABRAS)) ? 10'(PALABRAS) : n_palabras;
  assign w_unused_cpu_dir = ^{cpu_dir[31:ANCHO_DIR+2], cpu_dir[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado <= REPOSO;
    end else begin
      r_estado <= w_siguiente;
    end
  end

  always_comb begin
    w_siguiente = r_estado;
    case (r_estado)
      REPOSO: begin
        if (inicio) begin
          w_siguiente = (w_cuenta_lim == 10'd0) ? EJECUTA : CARGA;
        end else begin
          w_siguiente = REPOSO;
        end
      end
      CARGA: begin
        if (w_ultimo_byte && w_ultima_palabra) begin
          w_siguiente = FIN;
        end else begin
          w_siguiente = CARGA;
        end
      end
      FIN:     w_siguiente = EJECUTA;
      EJECUTA: w_siguiente = EJECUTA;
      default: w_siguiente = REPOSO;
    endcase
  end

  // The write register is separate from assembly so byte intake never stalls on a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cuenta    <= 10'd0;
      r_indice    <= 10'd0;
      r_byte_cnt  <= 2'd0;
      r_ensamble  <= 24'd0;
      r_escritura <= 32'd0;
      r_dir       <= '0;
      r_we        <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_estado)
        REPOSO: begin
          if (inicio) begin
            r_cuenta   <= w_cuenta_lim;
            r_indice   <= 10'd0;
            r_byte_cnt <= 2'd0;
            r_ensamble <= 24'd0;
          end
        end
        CARGA: begin
          if (w_acepta) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_escritura <= {bus.byte_dato, r_ensamble};
              r_dir       <= r_indice[ANCHO_DIR-1:0];
              r_we        <= 1'b1;
              r_indice    <= r_indice + 10'd1;
              r_ensamble  <= 24'd0;
            end else begin
              r_ensamble[8*r_byte_cnt +: 8] <= bus.byte_dato;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    bus.byte_listo = w_listo;
    cpu_reset      = 1'b1;
    ocupado        = 1'b0;
    hecho          = 1'b0;
    ram_dir        = r_dir;
    ram_din        = r_escritura;
    ram_we         = r_we;
    case (r_estado)
      CARGA, FIN: begin
        ocupado = 1'b1;
      end
      EJECUTA: begin
        cpu_reset = 1'b0;
        hecho     = 1'b1;
        ram_dir   = cpu_dir[ANCHO_DIR+1:2];
        ram_din   = cpu_dat_escritura;
        ram_we    = cpu_hab_escritura;
      end
      default: begin
        cpu_reset = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_cargador_programa.sv
// Scoreboard bench for cargador_programa: expected RAM writes are queued by stimulus
// and popped by a monitor whenever ram_we is seen.
module tb_cargador_programa;

  logic        clk;
  logic        reset;
  logic        inicio;
  logic [9:0]  n_palabras;
  logic [31:0] cpu_dir;
  logic [31:0] cpu_dat_escritura;
  logic        cpu_hab_escritura;
  logic [8:0]  ram_dir;
  logic [31:0] ram_din;
  logic        ram_we;
  logic        cpu_reset;
  logic        ocupado;
  logic        hecho;

  cargador_programa_if bus ();

  cargador_programa #(.PALABRAS(512), .ANCHO_DIR(9)) dut (
    .clk               (clk),
    .reset             (reset),
    .inicio            (inicio),
    .n_palabras        (n_palabras),
    .bus               (bus),
    .cpu_dir           (cpu_dir),
    .cpu_dat_escritura (cpu_dat_escritura),
    .cpu_hab_escritura (cpu_hab_escritura),
    .ram_dir           (ram_dir),
    .ram_din           (ram_din),
    .ram_we            (ram_we),
    .cpu_reset         (cpu_reset),
    .ocupado           (ocupado),
    .hecho             (hecho)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:511];
  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_dir] <= ram_din;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_we    = 0;
  logic [40:0] exp_q [$];

  task automatic check(input string nombre, input logic [63:0] actual, input logic [63:0] esperado);
    n_tests++;
    if (actual !== esperado) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nombre, actual, esperado);
    end
  endtask

  // Monitor: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      n_we++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got dir=%0d data=%h, expected no write", ram_dir, ram_din);
      end else begin
        check("ram_write", {23'd0, ram_dir, ram_din}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic start_load(input logic [9:0] n);
    inicio = 1'b1;
    n_palabras = n;
    @(posedge clk); #1;
    inicio = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    bit acc;
    ok = 1'b0;
    bus.byte_dato = b;
    bus.byte_valido = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      acc = bus.byte_listo;
      @(posedge clk); #1;
      ok = acc;
    end
    bus.byte_valido = 1'b0;
    if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic expect_write(input logic [8:0] d, input logic [31:0] w);
    exp_q.push_back({d, w});
  endtask

  task automatic check_drained(input string nombre);
    check(nombre, 64'(exp_q.size()), 64'd0);
  endtask

  int we_base;

  initial begin
    reset = 1'b0; inicio = 1'b0; n_palabras = 10'd0;
    cpu_dir = 32'd0; cpu_dat_escritura = 32'd0; cpu_hab_escritura = 1'b0;
    bus.byte_dato = 8'd0; bus.byte_valido = 1'b0;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    check("rst_outputs", {ram_dir, ram_din, ram_we, bus.byte_listo, cpu_reset, ocupado, hecho},
          {9'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    // Basic load, back-to-back bytes
    we_base = n_we;
    start_load(10'd2);
    check("basic_carga", {bus.byte_listo, ocupado, cpu_reset}, {1'b1, 1'b1, 1'b1});
    expect_write(9'd0, 32'h00000013);
    expect_write(9'd1, 32'h00100093);
    send_word(32'h00000013, 0);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    check("basic_fin", {cpu_reset, bus.byte_listo, ram_we, ram_dir}, {1'b1, 1'b0, 1'b1, 9'd1});
    @(posedge clk); #1;
    check("basic_release", {cpu_reset, hecho, ocupado}, {1'b0, 1'b1, 1'b0});
    check("basic_mem0", 64'(mem[0]), 64'h00000013);
    check("basic_mem1", 64'(mem[1]), 64'h00100093);
    check("basic_we_count", 64'(n_we - we_base), 64'd2);
    check_drained("basic_drained");

    // Throttled source with CPU write attempts during load
    do_reset();
    we_base = n_we;
    start_load(10'd2);
    cpu_dir = 32'h40; cpu_dat_escritura = 32'h12345678; cpu_hab_escritura = 1'b1;
    expect_write(9'd0, 32'h00000013);
    expect_write(9'd1, 32'h00100093);
    send_word(32'h00000013, 3);
    send_byte(8'h93); repeat (3) @(posedge clk); #1;
    send_byte(8'h00); repeat (3) @(posedge clk); #1;
    send_byte(8'h10); repeat (3) @(posedge clk); #1;
    send_byte(8'h00);
    cpu_hab_escritura = 1'b0;
    @(posedge clk); #1;
    check("thr_release", {cpu_reset, hecho}, {1'b0, 1'b1});
    check("thr_mem0", 64'(mem[0]), 64'h00000013);
    check("thr_mem1", 64'(mem[1]), 64'h00100093);
    check("thr_mem16_untouched", 64'(mem[16] === 32'h12345678), 64'd0);
    check("thr_we_count", 64'(n_we - we_base), 64'd2);
    check_drained("thr_drained");

    // Zero length
    do_reset();
    we_base = n_we;
    start_load(10'd0);
    check("zero_ejecuta", {cpu_reset, hecho, ocupado, bus.byte_listo}, {1'b0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("zero_no_we", 64'(n_we - we_base), 64'd0);

    // Oversize length clamps to 512 words
    do_reset();
    we_base = n_we;
    start_load(10'd600);
    for (int i = 0; i < 512; i++) begin
      expect_write(9'(i), 32'hA5000000 | 32'(i));
      send_word(32'hA5000000 | 32'(i), 0);
    end
    check("over_fin", {ram_we, ram_dir, cpu_reset}, {1'b1, 9'd511, 1'b1});
    @(posedge clk); #1;
    check("over_release", {cpu_reset, hecho}, {1'b0, 1'b1});
    check("over_we_count", 64'(n_we - we_base), 64'd512);
    check("over_mem511", 64'(mem[511]), 64'hA50001FF);
    check_drained("over_drained");

    // Reset after 6 bytes of a 2-word load
    do_reset();
    start_load(10'd2);
    expect_write(9'd0, 32'h11223344);
    send_word(32'h11223344, 0);
    send_byte(8'h55); send_byte(8'h66);
    do_reset();
    check("midrst_outputs", {cpu_reset, bus.byte_listo, ram_we, ocupado}, {1'b1, 1'b0, 1'b0, 1'b0});
    check("midrst_mem0", 64'(mem[0]), 64'h11223344);
    check("midrst_mem1_kept", 64'(mem[1]), 64'hA5000001);
    start_load(10'd1);
    expect_write(9'd0, 32'hCAFEF00D);
    send_word(32'hCAFEF00D, 0);
    @(posedge clk); #1;
    check("restart_mem0", 64'(mem[0]), 64'hCAFEF00D);
    check("restart_mem1", 64'(mem[1]), 64'hA5000001);
    check_drained("restart_drained");

    // Pass-through in EJECUTA
    cpu_dir = 32'h40; cpu_dat_escritura = 32'hDEADBEEF; cpu_hab_escritura = 1'b1;
    expect_write(9'd16, 32'hDEADBEEF);
    #1;
    check("pass_comb", {ram_dir, ram_we, ram_din}, {9'd16, 1'b1, 32'hDEADBEEF});
    @(posedge clk); #1;
    cpu_hab_escritura = 1'b0;
    #1;
    check("pass_mem16", 64'(mem[16]), 64'hDEADBEEF);
    check_drained("pass_drained");

    // Ignored start during CARGA and EJECUTA
    do_reset();
    we_base = n_we;
    start_load(10'd2);
    expect_write(9'd0, 32'h01020304);
    expect_write(9'd1, 32'h05060708);
    send_byte(8'h04); send_byte(8'h03); send_byte(8'h02);
    start_load(10'd1);
    check("ign_carga", {bus.byte_listo, ocupado}, {1'b1, 1'b1});
    send_byte(8'h01);
    send_word(32'h05060708, 0);
    @(posedge clk); #1;
    check("ign_mem0", 64'(mem[0]), 64'h01020304);
    check("ign_mem1", 64'(mem[1]), 64'h05060708);
    start_load(10'd3);
    @(posedge clk); #1;
    check("ign_ejecuta", {cpu_reset, hecho, bus.byte_listo}, {1'b0, 1'b1, 1'b0});
    check("ign_we_count", 64'(n_we - we_base), 64'd2);
    check_drained("ign_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cargador_programa.md
# cargador_programa

Boot-time program loader and RAM port sequencer for the single-core RV32I system. While `cpu_reset` holds the CPU in reset, the loader receives a byte stream over a valid/ready handshake and assembles it into little-endian 32-bit words. It writes those words to consecutive words of the 512x32 program/data RAM, then releases the CPU. From then on it hands the RAM port to the CPU through a pass-through multiplexer. The block sits between `cpu`, the RAM and an external byte source (UART receiver or bench).

## Interface
Parameters:
- `PALABRAS`, default 512: RAM capacity in words; load length is clamped to this value.
- `ANCHO_DIR`, default 9: RAM word-address width; must satisfy 2^ANCHO_DIR >= PALABRAS.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inicio`  in  1  start pulse; sampled only in REPOSO.
- `n_palabras`  in  10  number of words to load; latched when `inicio` is accepted.
- `byte_dato`  in  8  incoming program byte.
- `byte_valido`  in  1  `byte_dato` is valid.
- `byte_listo`  out  1  loader can accept a byte; a transfer happens on an edge where `byte_valido` and `byte_listo` are both 1.
- `cpu_dir`  in  32  CPU byte address.
- `cpu_dat_escritura`  in  32  CPU write data.
- `cpu_hab_escritura`  in  1  CPU write enable.
- `ram_dir`  out  ANCHO_DIR  RAM word address.
- `ram_din`  out  32  RAM write data.
- `ram_we`  out  1  RAM write enable.
- `cpu_reset`  out  1  CPU reset; high in every state except EJECUTA.
- `ocupado`  out  1  high in CARGA and FIN.
- `hecho`  out  1  high in EJECUTA.

## Operation
States and transitions:
- **REPOSO**
  - `inicio`=1 and latched count = 0 -> EJECUTA.
  - `inicio`=1 and latched count > 0 -> CARGA.
  - The latched count is min(`n_palabras`, PALABRAS).
- **CARGA**
  - `byte_listo`=1.
  - Bytes are assembled little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24]. A 2-bit byte counter tracks the position.
  - On acceptance of the 4th byte, the completed word is copied into a write register and a one-cycle write is scheduled at the current word index. The word index then increments.
  - The write register is separate from the assembly register, so the next byte may be accepted in the same cycle the previous word is written.
  - Acceptance of the 4th byte of the last word -> FIN.
  - `inicio` is ignored.
- **FIN**
  - `byte_listo`=0.
  - The final write is performed in this cycle.
  - Unconditionally -> EJECUTA.
- **EJECUTA**
  - `cpu_reset`=0, `hecho`=1, `byte_listo`=0.
  - `inicio` is ignored.
  - Only `reset` leaves this state.

RAM multiplexer:
- REPOSO, CARGA and FIN: `ram_dir`, `ram_din` and `ram_we` come from loader registers.
- EJECUTA: the outputs are combinational pass-through from the CPU:
  - `ram_dir` = `cpu_dir[ANCHO_DIR+1:2]`
  - `ram_din` = `cpu_dat_escritura`
  - `ram_we` = `cpu_hab_escritura`
- The CPU can never write to RAM before EJECUTA.

Counters:
- The word index is 10 bits, starts at 0 and wraps never, because the load length is clamped to PALABRAS.
- The loader's `ram_dir` equals the word index of the word being written.

## Timing
- Reset (synchronous):
  - state REPOSO, all counters cleared, assembly and write registers cleared.
  - Outputs after the reset edge: `ram_dir`=0, `ram_din`=0, `ram_we`=0, `byte_listo`=0, `cpu_reset`=1, `ocupado`=0, `hecho`=0.
- Write latency:
  - If the 4th byte of word w is accepted at edge k, then `ram_we`=1 with `ram_dir`=w during the cycle between edges k and k+1.
  - The RAM captures the word at edge k+1.
  - `ram_we` is high for exactly one cycle per word.
- Release latency: for the last word, FIN occupies that same cycle and EJECUTA begins at edge k+1, so `cpu_reset` falls one cycle after the last byte is accepted.
- Stalls: `byte_valido`=0 for any number of cycles simply holds the byte counter; there is no timeout.
- Reset mid-load (reset during CARGA or FIN):
  - The partial word is discarded and any pending write is cancelled (`ram_we`=0 after the edge).
  - The CPU stays in reset; words already written remain in RAM.
- `inicio` and `reset` on the same edge: reset wins.
- Maximum throughput is one byte per cycle, i.e. 4N cycles plus 1 for N words.

## Test plan
- **Basic load.** Reset, then `inicio` with `n_palabras`=2, then stream bytes 13,00,00,00,93,00,10,00 back-to-back.
  - RAM word 0 = 0x00000013, RAM word 1 = 0x00100093.
  - Exactly 2 `ram_we` pulses.
  - `cpu_reset` falls exactly 1 cycle after the 8th byte.
  - `hecho`=1 thereafter.
- **Throttled source.** Insert 3-cycle gaps in `byte_valido` between every byte.
  - Identical RAM contents to the basic load; no extra or duplicated writes.
- **Zero and oversize length.**
  - `n_palabras`=0: EJECUTA on the edge after `inicio`, no `ram_we` pulse.
  - `n_palabras`=600: exactly 512 writes, the last at `ram_dir`=511, then EJECUTA.
- **Reset mid-word.** Assert reset after 6 bytes of a 2-word load.
  - Only word 0 is written; `cpu_reset`=1, `byte_listo`=0, `ram_we`=0.
  - A new `inicio` restarts the load at address 0.
- **Pass-through and isolation.**
  - During CARGA, drive `cpu_hab_escritura`=1 with `cpu_dir`=0x40: no RAM write occurs.
  - In EJECUTA, `cpu_dir`=0x40 with write data 0xDEADBEEF and enable 1: `ram_dir`=16 and `ram_we`=1 in the same cycle, and RAM word 16 = 0xDEADBEEF.
- **Ignored start.** Pulse `inicio` during CARGA and during EJECUTA.
  - No state change, counters unchanged, `cpu_reset` stays 0 in EJECUTA.
